pipe_ctrl: RTL and testbench

//  Central pipeline controller for the 5-stage core. Collects stall requests from
//  IF/ID/EX/MEM and exception requests from MEM. Drives the per-stage stall vector
//  and the flush pulse used by pc_reg, if_id, id_ex, ex_mem and mem_wb.

---
 rtl/pipe_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the 5-stage core.
//
// Merges the stall requests from IF/ID/EX/MEM into one per-stage hold vector.
// The deepest requesting stage wins, and every stage upstream of it holds too.
// It turns a MEM exception, or a stall that lasts too long, into a one-cycle
// flush pulse with a PC redirect.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous reset, active low
//   stallreq_if   fetch waiting on instruction memory
//   stallreq_id   load-use hazard
//   stallreq_ex   multi-cycle EX op busy
//   stallreq_mem  data memory not ready
//   excp_i        exception committed in MEM this cycle
//   excp_pc_i     handler address accompanying excp_i
//   stall         [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB, 1 = hold stage
//   flush         one-cycle pulse, clears all pipeline registers
//   new_pc        redirect target, valid while flush=1, holds otherwise
//   wdog_timeout  sticky, the watchdog trap has fired since reset
//   stall_cnt     saturating count of cycles with stall != 0
//
// state | meaning
// RUN   | pipe flowing, no request seen last cycle
// STALL | pipe frozen by at least one request, watchdog counting
// FLUSH | one-cycle flush pulse; all requests ignored
module pipe_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter int                WDOG_MAX = 64,
  parameter logic [ADDR_W-1:0] TRAP_PC  = ADDR_W'(32'h0000_0040)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              excp_i,
  input  logic [ADDR_W-1:0] excp_pc_i,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic              wdog_timeout,
  output logic [31:0]       stall_cnt
);

  localparam int WDOG_W = (WDOG_MAX > 2) ? $clog2(WDOG_MAX) : 1;

  // The counter is 0 during the first STALL cycle. The trap fires on the
  // edge where the incremented value would reach WDOG_MAX-1. That gives
  // exactly WDOG_MAX stalled cycles, counting the RUN cycle that raised
  // the request.
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_MAX - 2);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t            state;
  logic [WDOG_W-1:0] wdog_cnt;
  logic              any_req;

  assign any_req = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;

  // Combinational so a stage holds in the same cycle it asks. It is gated
  // by rst so that an asserted reset silences the vector at once, even
  // while requests are still present.
  always_comb begin
    stall = 6'b000000;
    if (rst && (state != FLUSH) && !excp_i) begin
      if (stallreq_mem)      stall = 6'b011111;
      else if (stallreq_ex)  stall = 6'b001111;
      else if (stallreq_id)  stall = 6'b000111;
      else if (stallreq_if)  stall = 6'b000011;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      flush        <= 1'b0;
      new_pc       <= '0;
      wdog_timeout <= 1'b0;
      stall_cnt    <= '0;
      wdog_cnt     <= '0;
    end else begin
      flush <= 1'b0;

      if ((stall != 6'b000000) && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;

      case (state)
        RUN: begin
          if (excp_i) begin
            state  <= FLUSH;
            flush  <= 1'b1;
            new_pc <= excp_pc_i;
          end else if (any_req) begin
            state <= STALL;
          end
        end

        STALL: begin
          if (excp_i) begin
            // The exception outranks a watchdog expiry on the same cycle.
            state    <= FLUSH;
            flush    <= 1'b1;
            new_pc   <= excp_pc_i;
            wdog_cnt <= '0;
          end else if (!any_req) begin
            state    <= RUN;
            wdog_cnt <= '0;
          end else if (wdog_cnt == WDOG_LAST) begin
            state        <= FLUSH;
            flush        <= 1'b1;
            new_pc       <= TRAP_PC;
            wdog_timeout <= 1'b1;
            wdog_cnt     <= '0;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
        end

        FLUSH: state <= RUN;

        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector bench for pipe_ctrl (default parameters:
// WDOG_MAX=64, TRAP_PC=0x40). Inputs change 1 ns after a rising edge.
// Outputs are sampled on the falling edge.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        excp_i;
  logic [31:0] excp_pc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        wdog_timeout;
  logic [31:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excp_i       (excp_i),
    .excp_pc_i    (excp_pc_i),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .wdog_timeout (wdog_timeout),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b0;
    stallreq_if  = 1'b0;
    stallreq_id  = 1'b0;
    stallreq_ex  = 1'b0;
    stallreq_mem = 1'b0;
    excp_i       = 1'b0;
    excp_pc_i    = 32'h0;

    // Reset values, then 20 idle cycles.
    #12;
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_new_pc", new_pc, 32'h0);
    check("rst_wdog", 32'(wdog_timeout), 32'h0);
    check("rst_cnt", stall_cnt, 32'h0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sample();
      check("idle_stall", 32'(stall), 32'h0);
      check("idle_flush", 32'(flush), 32'h0);
      tick();
    end
    check("idle_cnt", stall_cnt, 32'h0);

    // Load-use stall, 3 cycles.
    stallreq_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("id_stall", 32'(stall), 32'h07);
      tick();
    end
    stallreq_id = 1'b0;
    sample();
    check("id_release", 32'(stall), 32'h0);
    tick();
    check("id_cnt", stall_cnt, 32'd3);
    check("id_flush", 32'(flush), 32'h0);

    // IF and MEM together: MEM is deeper and wins.
    stallreq_if  = 1'b1;
    stallreq_mem = 1'b1;
    sample();
    check("ifmem_stall", 32'(stall), 32'h1F);
    tick();
    stallreq_if  = 1'b0;
    stallreq_mem = 1'b0;
    tick();
    check("ifmem_cnt", stall_cnt, 32'd4);

    // Exception during an EX stall.
    stallreq_ex = 1'b1;
    sample();
    check("ex_stall", 32'(stall), 32'h0F);
    tick();
    excp_i    = 1'b1;
    excp_pc_i = 32'h0000_0020;
    sample();
    check("excp_stall", 32'(stall), 32'h0);
    check("excp_noflush", 32'(flush), 32'h0);
    tick();
    excp_i    = 1'b0;
    excp_pc_i = 32'h0;
    sample();
    check("excp_flush", 32'(flush), 32'h1);
    check("excp_new_pc", new_pc, 32'h20);
    check("excp_flush_stall", 32'(stall), 32'h0);
    tick();
    stallreq_ex = 1'b0;
    sample();
    check("excp_pulse_end", 32'(flush), 32'h0);
    check("excp_pc_hold", new_pc, 32'h20);
    check("excp_wdog", 32'(wdog_timeout), 32'h0);
    tick();
    check("excp_cnt", stall_cnt, 32'd5);

    // The exception outranks the watchdog. Cycle 64 is the watchdog's trigger
    // cycle, and an exception arrives on that same cycle.
    stallreq_ex = 1'b1;
    for (int i = 1; i <= 63; i++) begin
      sample();
      if (stall !== 6'h0F || flush !== 1'b0)
        check("race_hold", {25'h0, flush, stall}, 32'h0F);
      tick();
    end
    excp_i    = 1'b1;
    excp_pc_i = 32'h0000_0088;
    sample();
    check("race_stall", 32'(stall), 32'h0);
    tick();
    excp_i      = 1'b0;
    stallreq_ex = 1'b0;
    sample();
    check("race_flush", 32'(flush), 32'h1);
    check("race_new_pc", new_pc, 32'h88);
    check("race_no_wdog", 32'(wdog_timeout), 32'h0);
    tick();
    check("race_cnt", stall_cnt, 32'd68);

    // Watchdog: EX held 64 cycles, then a trap flush on cycle 65.
    stallreq_ex = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      sample();
      if (stall !== 6'h0F || flush !== 1'b0)
        check("wdog_hold", {25'h0, flush, stall}, 32'h0F);
      tick();
    end
    sample();
    check("wdog_flush", 32'(flush), 32'h1);
    check("wdog_new_pc", new_pc, 32'h40);
    check("wdog_flag", 32'(wdog_timeout), 32'h1);
    check("wdog_stall", 32'(stall), 32'h0);
    tick();
    stallreq_ex = 1'b0;
    sample();
    check("wdog_pulse_end", 32'(flush), 32'h0);
    check("wdog_sticky", 32'(wdog_timeout), 32'h1);
    tick();
    check("wdog_cnt", stall_cnt, 32'd132);

    // Asynchronous reset in the middle of a STALL.
    stallreq_mem = 1'b1;
    tick();
    tick();
    tick();
    check("pre_rst_cnt", stall_cnt, 32'd135);
    #2;
    rst = 1'b0;
    #1;
    check("arst_stall", 32'(stall), 32'h0);
    check("arst_flush", 32'(flush), 32'h0);
    check("arst_new_pc", new_pc, 32'h0);
    check("arst_wdog", 32'(wdog_timeout), 32'h0);
    check("arst_cnt", stall_cnt, 32'h0);
    stallreq_mem = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    sample();
    check("post_rst_stall", 32'(stall), 32'h0);
    check("post_rst_cnt", stall_cnt, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
